// File: rtl/vga_image_reader_if.sv
// Signal bundle between the scan-out stage, the image RAM read port and the VGA connector.
// The reader is the master; the RAM model / monitor side is the slave.
interface vga_image_reader_if #(
  parameter int AddressWidth = 14,
  parameter int DataWidth    = 8
);
  logic                    ram_rw;
  logic [AddressWidth-1:0] ram_addr;
  logic [DataWidth-1:0]    ram_data;
  logic [2:0]              red;
  logic [2:0]              green;
  logic [1:0]              blue;
  logic                    hsync;
  logic                    vsync;
  logic                    de;
  logic                    frame_start;

  modport master (
    output ram_rw, ram_addr, red, green, blue, hsync, vsync, de, frame_start,
    input  ram_data
  );

  modport slave (
    input  ram_rw, ram_addr, red, green, blue, hsync, vsync, de, frame_start,
    output ram_data
  );
endinterface

// File: rtl/vga_image_reader.sv
// VGA scan-out stage: raster counters, image RAM address generation and a 3-stage
// pipeline that keeps colour, syncs, de and frame_start aligned at the pins.
module vga_image_reader #(
  parameter int         AddressWidth = 14,
  parameter int         DataWidth    = 8,
  parameter int         ImgWidth     = 128,
  parameter int         ImgHeight    = 128,
  parameter int         XOffset      = 256,
  parameter int         YOffset      = 176,
  parameter logic [7:0] BgColor      = 8'h00,
  parameter int         HVisible     = 640,
  parameter int         HFront       = 16,
  parameter int         HSync        = 96,
  parameter int         HBack        = 48,
  parameter int         VVisible     = 480,
  parameter int         VFront       = 10,
  parameter int         VSync        = 2,
  parameter int         VBack        = 33
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_image_reader_if.master  bus
);
  localparam int HTotal = HVisible + HFront + HSync + HBack;
  localparam int VTotal = VVisible + VFront + VSync + VBack;
  localparam int HW     = $clog2(HTotal);
  localparam int VW     = $clog2(VTotal);

  localparam logic [HW-1:0] HLast   = HW'(HTotal - 1);
  localparam logic [VW-1:0] VLast   = VW'(VTotal - 1);
  localparam logic [31:0]   HVis    = 32'(HVisible);
  localparam logic [31:0]   VVis    = 32'(VVisible);
  localparam logic [31:0]   HSyncLo = 32'(HVisible + HFront);
  localparam logic [31:0]   HSyncHi = 32'(HVisible + HFront + HSync);
  localparam logic [31:0]   VSyncLo = 32'(VVisible + VFront);
  localparam logic [31:0]   VSyncHi = 32'(VVisible + VFront + VSync);
  localparam logic [31:0]   XLo     = 32'(XOffset);
  localparam logic [31:0]   XHi     = 32'(XOffset + ImgWidth);
  localparam logic [31:0]   YLo     = 32'(YOffset);
  localparam logic [31:0]   YHi     = 32'(YOffset + ImgHeight);

  // Flag bit order inside the pipeline words.
  localparam int FVis = 0, FImg = 1, FHs = 2, FVs = 3, FFs = 4;

  logic [HW-1:0]           h_reg;
  logic [VW-1:0]           v_reg;
  logic [AddressWidth-1:0] idx_reg;
  logic [AddressWidth-1:0] addr_reg;
  logic [4:0]              s1_flags_reg;
  logic [4:0]              s2_flags_reg;
  logic [31:0]             hx;
  logic [31:0]             vx;
  logic [4:0]              flags_now;
  logic                    first;
  logic                    in_img;
  logic                    frame_wrap;
  logic [7:0]              pix;

  assign hx = 32'(h_reg);
  assign vx = 32'(v_reg);

  always_comb begin
    first      = (h_reg == '0) && (v_reg == '0);
    frame_wrap = (h_reg == HLast) && (v_reg == VLast);
    in_img     = (hx >= XLo) && (hx < XHi) && (vx >= YLo) && (vx < YHi);
    flags_now        = '0;
    flags_now[FVis]  = (hx < HVis) && (vx < VVis);
    flags_now[FImg]  = in_img;
    flags_now[FHs]   = (hx >= HSyncLo) && (hx < HSyncHi);
    flags_now[FVs]   = (vx >= VSyncLo) && (vx < VSyncHi);
    flags_now[FFs]   = first;
  end

  // ram_data belongs to the pixel whose flags sit in stage 2.
  always_comb begin
    pix = 8'h00;
    if (s2_flags_reg[FImg])
      pix = bus.ram_data;
    else if (s2_flags_reg[FVis])
      pix = BgColor;
  end

  assign bus.ram_rw   = 1'b1;
  assign bus.ram_addr = addr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg           <= '0;
      v_reg           <= '0;
      idx_reg         <= '0;
      addr_reg        <= '0;
      s1_flags_reg    <= '0;
      s2_flags_reg    <= '0;
      bus.red         <= '0;
      bus.green       <= '0;
      bus.blue        <= '0;
      bus.hsync       <= 1'b1;
      bus.vsync       <= 1'b1;
      bus.de          <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      if (h_reg == HLast) begin
        h_reg <= '0;
        v_reg <= (v_reg == VLast) ? '0 : v_reg + VW'(1);
      end else begin
        h_reg <= h_reg + HW'(1);
      end

      // Running count of image pixels this frame; wraps naturally at 2**AddressWidth.
      if (frame_wrap)
        idx_reg <= '0;
      else if (in_img)
        idx_reg <= idx_reg + AddressWidth'(1);

      if (first || in_img)
        addr_reg <= idx_reg;

      s1_flags_reg <= flags_now;
      s2_flags_reg <= s1_flags_reg;

      bus.red         <= pix[7:5];
      bus.green       <= pix[4:2];
      bus.blue        <= pix[1:0];
      bus.hsync       <= ~s2_flags_reg[FHs];
      bus.vsync       <= ~s2_flags_reg[FVs];
      bus.de          <= s2_flags_reg[FVis];
      bus.frame_start <= s2_flags_reg[FFs];
    end
  end
endmodule
